// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and types for the 8-bit accumulator CPU
//                control path: bus-select codes, opcodes, ALU ops, FSM
//                state encoding and the decoded strobe bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcode field width (IR[7:5])
    localparam int CPU_OPC_W = 3;

    // Bus mux select codes
    localparam logic [1:0] BUS_MEM = 2'b00;
    localparam logic [1:0] BUS_DR  = 2'b01;
    localparam logic [1:0] BUS_PC  = 2'b10;
    localparam logic [1:0] BUS_AC  = 2'b11;

    // Opcodes
    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    // ALU operations
    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_AND  = 2'b11;

    // Sequencer state encoding; codes 6 and 7 are illegal
    typedef enum logic [2:0] {
        ST_FETCH_A = 3'd0,
        ST_FETCH_I = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC1   = 3'd3,
        ST_EXEC2   = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    // Everything the sequencer drives in one cycle
    typedef struct packed {
        logic [1:0] bus_sel;
        logic       ar_ld;
        logic       ir_ld;
        logic       dr_ld;
        logic       ac_ld;
        logic       pc_ld;
        logic       pc_inc;
        logic       mem_we;
        logic [1:0] alu_op;
        logic       halted;
    } strobes_t;

    // Instructions that fetch a memory operand into DR and then load AC
    function automatic logic is_mem_operand(input logic [2:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

    // ALU operation used when a memory-operand instruction loads AC
    function automatic logic [1:0] alu_for(input logic [2:0] op);
        logic [1:0] r;
        case (op)
            OP_ADD:  r = ALU_ADD;
            OP_SUB:  r = ALU_SUB;
            OP_AND:  r = ALU_AND;
            default: r = ALU_PASS;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_if
//  Description : Controller <-> datapath signal bundle. The master modport
//                is the sequencer, the slave modport is the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_unit_if;
    import cpu_pkg::*;

    logic [CPU_OPC_W-1:0] ir_op;
    logic                 ac_zero;
    logic [1:0]           bus_sel;
    logic                 ar_ld;
    logic                 ir_ld;
    logic                 dr_ld;
    logic                 ac_ld;
    logic                 pc_ld;
    logic                 pc_inc;
    logic                 mem_we;
    logic [1:0]           alu_op;
    logic                 halted;
    logic [2:0]           tstate;

    modport master (
        input  ir_op, ac_zero,
        output bus_sel, ar_ld, ir_ld, dr_ld, ac_ld, pc_ld, pc_inc, mem_we,
               alu_op, halted, tstate
    );

    modport slave (
        output ir_op, ac_zero,
        input  bus_sel, ar_ld, ir_ld, dr_ld, ac_ld, pc_ld, pc_inc, mem_we,
               alu_op, halted, tstate
    );

endinterface
`default_nettype wire

// File: rtl/cu_decode.sv
`default_nettype none
// ============================================================================
//  Module      : cu_decode
//  Description : Purely combinational decode of (state, ir_op, ac_zero) into
//                the controller strobe bundle. kill forces the idle bundle
//                (bus on PC, no strobes, not halted).
//  Revision    : 1.0 - initial release
// ============================================================================
module cu_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] ir_op,
    input  logic       ac_zero,
    input  logic       kill,
    output strobes_t   strb
);

    // Per-state strobe decode; anything not named stays at its idle value
    always_comb begin
        strb         = '0;
        strb.bus_sel = BUS_PC;
        strb.alu_op  = ALU_PASS;
        if (!kill) begin
            case (state)
                ST_FETCH_A: begin
                    strb.bus_sel = BUS_PC;
                    strb.ar_ld   = 1'b1;
                end
                ST_FETCH_I: begin
                    strb.bus_sel = BUS_MEM;
                    strb.ir_ld   = 1'b1;
                    strb.dr_ld   = 1'b1;
                    strb.pc_inc  = 1'b1;
                end
                ST_DECODE: begin
                    // Operand address comes from the low bits of DR
                    strb.bus_sel = BUS_DR;
                    strb.ar_ld   = 1'b1;
                end
                ST_EXEC1: begin
                    if (is_mem_operand(ir_op)) begin
                        strb.bus_sel = BUS_MEM;
                        strb.dr_ld   = 1'b1;
                    end else if (ir_op == OP_STA) begin
                        strb.bus_sel = BUS_AC;
                        strb.mem_we  = 1'b1;
                    end else if (ir_op == OP_JMP) begin
                        strb.bus_sel = BUS_DR;
                        strb.pc_ld   = 1'b1;
                    end else if (ir_op == OP_JZ) begin
                        strb.bus_sel = BUS_DR;
                        strb.pc_ld   = ac_zero;
                    end
                end
                ST_EXEC2: begin
                    strb.bus_sel = BUS_DR;
                    strb.ac_ld   = 1'b1;
                    strb.alu_op  = alu_for(ir_op);
                end
                ST_HALT: begin
                    strb.halted  = 1'b1;
                end
                default: begin
                    // Illegal codes: idle bundle, recovery is in the state register
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Multi-cycle sequencer for the 8-bit accumulator CPU. Holds
//                the state register and next-state logic; strobes are
//                decoded combinationally by cu_decode.
//                Optional build macro CU_SINGLE_STEP_EN adds a 'step' input
//                that gates FETCH_A so each pulse runs one instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int OPC_W  = 3
) (
    input  logic            clk,
    input  logic            rst,
`ifdef CU_SINGLE_STEP_EN
    input  logic            step,
`endif
    control_unit_if.master  cu
);

    // The opcode field and address must fit the datapath word
    if ((OPC_W != CPU_OPC_W) || (ADDR_W > DATA_W)) begin : g_cfg_err
        $error("control_unit: unsupported DATA_W/ADDR_W/OPC_W combination");
    end

    state_t   r_state;
    strobes_t w_strb;
    logic     w_go;
    logic     w_kill;

`ifdef CU_SINGLE_STEP_EN
    assign w_go = step;
`else
    assign w_go = 1'b1;
`endif

    // Reset idles the outputs; FETCH_A without a step also idles them
    assign w_kill = rst || ((r_state == ST_FETCH_A) && !w_go);

    // State register and next-state logic
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH_A;
        end else begin
            case (r_state)
                ST_FETCH_A: r_state <= w_go ? ST_FETCH_I : ST_FETCH_A;
                ST_FETCH_I: r_state <= ST_DECODE;
                ST_DECODE:  r_state <= (cu.ir_op == OP_HLT) ? ST_HALT : ST_EXEC1;
                ST_EXEC1:   r_state <= is_mem_operand(cu.ir_op) ? ST_EXEC2 : ST_FETCH_A;
                ST_EXEC2:   r_state <= ST_FETCH_A;
                ST_HALT:    r_state <= ST_HALT;
                default:    r_state <= ST_FETCH_A;
            endcase
        end
    end

    cu_decode u_decode (
        .state   (r_state),
        .ir_op   (cu.ir_op),
        .ac_zero (cu.ac_zero),
        .kill    (w_kill),
        .strb    (w_strb)
    );

    assign cu.bus_sel = w_strb.bus_sel;
    assign cu.ar_ld   = w_strb.ar_ld;
    assign cu.ir_ld   = w_strb.ir_ld;
    assign cu.dr_ld   = w_strb.dr_ld;
    assign cu.ac_ld   = w_strb.ac_ld;
    assign cu.pc_ld   = w_strb.pc_ld;
    assign cu.pc_inc  = w_strb.pc_inc;
    assign cu.mem_we  = w_strb.mem_we;
    assign cu.alu_op  = w_strb.alu_op;
    assign cu.halted  = w_strb.halted;
    assign cu.tstate  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Self-checking bench for control_unit. A reference model
//                tracks the instruction phase (cycle index within the
//                current instruction) and predicts every output each cycle.
//                Honours CU_SINGLE_STEP_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef CU_SINGLE_STEP_EN
    logic step = 1'b1;
`endif

    control_unit_if cu_if ();

    control_unit dut (
        .clk  (clk),
        .rst  (rst),
`ifdef CU_SINGLE_STEP_EN
        .step (step),
`endif
        .cu   (cu_if)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: phase within instruction, opcode, halted flag
    int         m_k      = 0;
    bit         m_halted = 1'b0;
    logic [2:0] m_op     = 3'd0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // {tstate, halted, alu_op, mem_we, pc_inc, pc_ld, ac_ld, dr_ld, ir_ld, ar_ld, bus_sel}
    function automatic logic [31:0] observed();
        return {16'd0, cu_if.tstate, cu_if.halted, cu_if.alu_op, cu_if.mem_we,
                cu_if.pc_inc, cu_if.pc_ld, cu_if.ac_ld, cu_if.dr_ld, cu_if.ir_ld,
                cu_if.ar_ld, cu_if.bus_sel};
    endfunction

    // One clock cycle: drive inputs, check predicted outputs, advance model
    task automatic tick(input logic r, input logic az, input logic [2:0] nop);
        logic [1:0] e_bus, e_alu;
        logic e_ar, e_ir, e_dr, e_ac, e_pcld, e_inc, e_we, e_halt, go, memop;
        logic [2:0] e_ts;
        @(negedge clk);
        if (m_k == 0 && !m_halted) m_op = nop;
        rst           = r;
        cu_if.ac_zero = az;
        // Before the IR is loaded the opcode field is junk
        cu_if.ir_op   = (m_k >= 2 && !m_halted) ? m_op : 3'($urandom_range(0, 7));
`ifdef CU_SINGLE_STEP_EN
        go = step;
`else
        go = 1'b1;
`endif
        memop = (m_op == 3'b000) || (m_op == 3'b010) || (m_op == 3'b011) || (m_op == 3'b100);
        #1;
        e_bus = 2'b10; e_alu = 2'b00;
        {e_ar, e_ir, e_dr, e_ac, e_pcld, e_inc, e_we} = '0;
        e_halt = 1'b0;
        e_ts   = m_halted ? 3'd5 : 3'(m_k);
        if (!r) begin
            if (m_halted) e_halt = 1'b1;
            else case (m_k)
                0: e_ar = go;
                1: begin e_bus = 2'b00; e_ir = 1; e_dr = 1; e_inc = 1; end
                2: begin e_bus = 2'b01; e_ar = 1; end
                3: begin
                    if (memop) begin e_bus = 2'b00; e_dr = 1; end
                    else if (m_op == 3'b001) begin e_bus = 2'b11; e_we = 1; end
                    else if (m_op == 3'b101) begin e_bus = 2'b01; e_pcld = 1; end
                    else if (m_op == 3'b110) begin e_bus = 2'b01; e_pcld = az; end
                end
                4: begin
                    e_bus = 2'b01; e_ac = 1;
                    e_alu = (m_op == 3'b010) ? 2'd1 : (m_op == 3'b011) ? 2'd2 :
                            (m_op == 3'b100) ? 2'd3 : 2'd0;
                end
                default: ;
            endcase
        end
        check($sformatf("outputs k=%0d op=%0d rst=%0d", m_k, m_op, r), observed(),
              {16'd0, e_ts, e_halt, e_alu, e_we, e_inc, e_pcld, e_ac, e_dr, e_ir, e_ar, e_bus});
        check("inv_inc_and_ld", 32'(cu_if.pc_inc & cu_if.pc_ld), 32'd0);
        check("inv_we_bus", 32'(cu_if.mem_we && cu_if.bus_sel != 2'b11), 32'd0);
        check("inv_ar_we", 32'(cu_if.ar_ld & cu_if.mem_we), 32'd0);
        // Advance the model
        if (r) begin
            m_k = 0; m_halted = 1'b0;
        end else if (!m_halted) begin
            case (m_k)
                0: if (go) m_k = 1;
                1: m_k = 2;
                2: if (m_op == 3'b111) m_halted = 1'b1; else m_k = 3;
                3: m_k = memop ? 4 : 0;
                default: m_k = 0;
            endcase
        end
    endtask

    task automatic run(input int n, input logic [2:0] op, input logic az);
        for (int i = 0; i < n; i++) tick(1'b0, az, op);
    endtask

    initial begin
        cu_if.ir_op   = 3'd0;
        cu_if.ac_zero = 1'b0;
        // Unchecked edge to bring the state register out of its power-up value
        rst = 1'b1;
        @(posedge clk);
        tick(1'b1, 1'b0, 3'd0);
        tick(1'b1, 1'b0, 3'd0);
        run(5, OP_LDA, 1'b0);
        run(4, OP_STA, 1'b1);
        run(4, OP_JZ, 1'b1);
        run(4, OP_JZ, 1'b0);
        run(4, OP_JMP, 1'b0);
        run(5, OP_SUB, 1'b1);
        run(23, OP_HLT, 1'b0);
        tick(1'b1, 1'b0, 3'd0);
        // ADD interrupted by reset in EXEC1
        run(3, OP_ADD, 1'b0);
        tick(1'b1, 1'b0, OP_ADD);
        run(5, OP_AND, 1'b0);
`ifdef CU_SINGLE_STEP_EN
        step = 1'b0;
        run(4, OP_LDA, 1'b0);
        step = 1'b1;
        tick(1'b0, 1'b0, OP_LDA);
        step = 1'b0;
        run(8, OP_ADD, 1'b0);
        step = 1'b1;
`endif
        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
`ifdef CU_SINGLE_STEP_EN
            step = 1'($urandom_range(0, 1));
`endif
            tick(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)));
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle FSM sequencer for the 8-bit accumulator CPU.
- Drives the 4-source bus mux select and all register load strobes, memory write and ALU op, for one instruction at a time.
- Sits between the IR/AC status and the datapath; the only owner of the bus select.

Parameters:
- DATA_W, 8, datapath width.
- ADDR_W, 5, PC/AR width (32-word memory).
- OPC_W, 3, opcode width (IR[7:5]).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ir_op  in  OPC_W  opcode field of the registered IR.
- ac_zero  in  1  AC == 0, from the datapath.
- bus_sel  out  2  bus mux select: 00 mem, 01 DR, 10 PC, 11 AC.
- ar_ld  out  1  AR loads bus[ADDR_W-1:0].
- ir_ld  out  1  IR loads bus.
- dr_ld  out  1  DR loads bus.
- ac_ld  out  1  AC loads ALU result.
- pc_ld  out  1  PC loads bus[ADDR_W-1:0].
- pc_inc  out  1  PC increments, wrapping 31 -> 0.
- mem_we  out  1  memory[AR] <= bus.
- alu_op  out  2  00 PASS(DR), 01 ADD, 10 SUB, 11 AND.
- halted  out  1  high in HALT.
- tstate  out  3  current state code (debug).

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- States: FETCH_A=0, FETCH_I=1, DECODE=2, EXEC1=3, EXEC2=4, HALT=5.
  - Codes 6-7 are illegal and go to FETCH_A next cycle with all strobes 0.
- Outputs are combinational decode of the registered state, ir_op and ac_zero.
- Strobes not listed for a state are 0.
- Default bus_sel: 10 (PC).
- Default alu_op: 00.
- Reset:
  - When rst is high at an edge: state <= FETCH_A.
  - While rst is high: all strobes 0, bus_sel=10, halted=0.
  - rst mid-instruction abandons it; no partial write beyond the current cycle.
- FETCH_A: bus_sel=10, ar_ld=1 -> FETCH_I.
- FETCH_I: bus_sel=00, ir_ld=1, dr_ld=1, pc_inc=1 -> DECODE.
- DECODE: bus_sel=01, ar_ld=1 (operand address from DR[4:0]). Next state:
  - HLT -> HALT.
  - otherwise -> EXEC1.
- Opcodes: LDA=000, STA=001, ADD=010, SUB=011, AND=100, JMP=101, JZ=110, HLT=111.
- EXEC1:
  - LDA/ADD/SUB/AND: bus_sel=00, dr_ld=1 -> EXEC2.
  - STA: bus_sel=11, mem_we=1 -> FETCH_A.
  - JMP: bus_sel=01, pc_ld=1 -> FETCH_A.
  - JZ: bus_sel=01, pc_ld=ac_zero -> FETCH_A. ac_zero is sampled in EXEC1 only.
- EXEC2: bus_sel=01, ac_ld=1, alu_op = PASS / ADD / SUB / AND for LDA / ADD / SUB / AND -> FETCH_A.
- HALT:
  - halted=1, all strobes 0; held until rst.
- Latency per instruction:
  - 5 cycles: LDA, ADD, SUB, AND.
  - 4 cycles: STA, JMP, JZ.
  - 3 cycles to HALT.
- Simultaneous events:
  - pc_inc and pc_ld are never both 1.
  - mem_we is only ever 1 with bus_sel=11.
  - ar_ld and mem_we are never in the same cycle.
- PC wrap: pc_inc at PC=31 yields 0; this is datapath behaviour, and the controller does not special-case it.
- ir_op is read only in DECODE, EXEC1 and EXEC2 (it is stable after FETCH_I).

Optional Feature:
- Macro: CU_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - FETCH_A asserts its strobes and advances only when step=1; otherwise it holds with all strobes 0.
  - step is ignored in every other state, so one pulse executes exactly one instruction.
- Undefined:
  - No step port; FETCH_A always advances.

Decomposition:
- Package cpu_pkg holds:
  - Bus-select constants: BUS_MEM, BUS_DR, BUS_PC, BUS_AC.
  - Opcode constants.
  - ALU op constants.
  - State encoding constants.
- One natural sub-module: cu_decode, a purely combinational (state, ir_op, ac_zero) -> strobe bundle.
- control_unit keeps the state register and next-state logic.

Test Plan:
- Reset: rst=1 for 2 cycles -> tstate=0, all strobes 0, bus_sel=10; first cycle after release: ar_ld=1, bus_sel=10.
- LDA 5 (ir_op=000): sequence over 5 cycles:
  - bus_sel = 10, 00, 01, 00, 01.
  - ar_ld, ir_ld+dr_ld+pc_inc, ar_ld, dr_ld, then ac_ld with alu_op=00.
  - Back at tstate=0.
- STA (001): EXEC1 shows bus_sel=11, mem_we=1, with ar_ld=0 that cycle; total 4 cycles.
- JZ (110):
  - ac_zero=1 -> pc_ld=1, bus_sel=01 in EXEC1.
  - Repeat with ac_zero=0 -> pc_ld=0; both return to FETCH_A after 4 cycles.
- SUB (011): EXEC2 alu_op=10, ac_ld=1. Then HLT (111) -> halted=1 from the 4th cycle onward, strobes 0 for 20 cycles; rst -> halted=0.
- rst asserted in EXEC1 of ADD -> next cycle tstate=0, no dr_ld. With CU_SINGLE_STEP_EN and step=0: holds in FETCH_A with ar_ld=0; one step pulse -> exactly one instruction runs.
